cmult_stream: RTL and testbench
===============================

CMULT_STREAM -- requirements
Module: cmult_stream

Interface
REQ-001 Parameter WORD_SIZE, default 16: bit width of each real and imaginary component.
REQ-002 Parameter FRAC_BITS, default WORD_SIZE-1: fractional bits of the Q format; legal range 1..WORD_SIZE-1.
REQ-003 Parameter TAG_W, default 8: width of the sideband tag carried alongside each sample.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 i_valid  input  1: input sample present.
REQ-007 i_ready  output  1: block accepts the input sample this cycle.
REQ-008 A  input  2*WORD_SIZE: signed operand; real part in the upper half, imaginary part in the lower half.
REQ-009 B  input  2*WORD_SIZE: signed operand, same packing as A.
REQ-010 i_conj  input  1: per-sample mode; 1 = compute A*conj(B), 0 = compute A*B.
REQ-011 i_rnd  input  1: per-sample mode; 1 = round half up, 0 = truncate toward minus infinity.
REQ-012 i_tag  input  TAG_W: sideband tag, passed through unchanged.
REQ-013 o_valid  output  1: output sample present.
REQ-014 o_ready  input  1: downstream accepts the output sample.
REQ-015 C  output  2*WORD_SIZE: result, packed the same way as A.
REQ-016 o_ovf  output  1: real or imaginary result saturated for this sample.
REQ-017 o_tag  output  TAG_W: tag of the output sample.

Function
REQ-018 A transfer SHALL occur on any rising edge where valid and ready are both 1, for input and output independently.
REQ-019 Pipeline SHALL have 3 registered stages: S1 the four products (2*WORD_SIZE signed each); S2 the sums; S3 round, shift, saturate, registered outputs.
REQ-020 S1 and S2 SHALL carry the valid, conj, rnd and tag bits of their sample.
REQ-021 Products: RR=Ar*Br, II=Ai*Bi, RI=Ar*Bi, IR=Ai*Br.
REQ-022 S2 with conj=0 SHALL form Re=RR-II and Im=RI+IR; with conj=1, Re=RR+II and Im=IR-RI; sums are 2*WORD_SIZE+1 bits signed, with no wrap.
REQ-023 S3, when rnd=1, SHALL add 2^(FRAC_BITS-1) to each sum, then arithmetic-shift right by FRAC_BITS.
REQ-024 A shifted value above 2^(WORD_SIZE-1)-1 SHALL clamp to that maximum; a value below -2^(WORD_SIZE-1) SHALL clamp to that minimum; o_ovf = clamp on Re OR clamp on Im.
REQ-025 With no stall, a sample accepted on edge t SHALL be presented on C/o_tag/o_ovf with o_valid=1 after edge t+2.
REQ-026 Stage k SHALL load when it is empty or stage k+1 loads; S3 loads when o_valid=0 or o_ready=1.
REQ-027 i_ready SHALL equal the S1 load condition, which is combinational from o_ready and the stage valids, with no combinational path from i_valid.
REQ-028 Bubbles SHALL collapse: an empty stage loads even while o_ready=0.
REQ-029 While o_valid=1 and o_ready=0, C, o_ovf and o_tag SHALL hold stable.
REQ-030 Samples SHALL leave in acceptance order, with none dropped or duplicated.
REQ-031 Capacity SHALL be 3 samples; with o_ready held 0, i_ready SHALL go 0 after exactly 3 accepted samples.
REQ-032 Simultaneous output drain and input accept in a full pipeline SHALL sustain 1 sample/cycle.
REQ-033 A stage that is not loading SHALL hold its data registers.
REQ-034 Data registers of empty stages are don't-care, but C SHALL be 0 whenever o_valid=0.

Reset
REQ-035 reset=0 SHALL immediately clear all stage valids, o_valid, o_ovf, C and o_tag to 0, independent of clk.
REQ-036 i_ready SHALL be 1 on the first edge after reset deasserts.
REQ-037 Samples in flight during reset SHALL be discarded, with no output produced for them.

Verification
REQ-038 Q1.15, rnd=0, conj=0: A=0x4000_4000, B=0x4000_C000 -> C=0x4000_0000, o_ovf=0, 3-cycle latency.
REQ-039 A=0x8000_0000, B=0x8000_0000 -> C=0x7FFF_0000, o_ovf=1.
REQ-040 A=0x0000_4000, B=0x0000_4000: conj=1 -> C=0x2000_0000; conj=0 -> C=0xE000_0000.
REQ-041 A=0x0001_0000, B=0x4000_0000: rnd=1 -> C=0x0001_0000; rnd=0 -> C=0x0000_0000.
REQ-042 o_ready=0 with 5 back-to-back inputs (tags 1..5) -> exactly 3 accepted and i_ready=0; then o_ready=1 -> tags 1..5 in order with C stable during the stall.
REQ-043 Random stream with random o_ready, with reset=0 pulsed mid-stream -> outputs match a reference model, and no pre-reset sample appears after reset.

Source files
------------

// File: rtl/cmult_stream.sv
// cmult_stream: 3-stage streaming complex multiplier (A*B or A*conj(B)) with
// per-sample round/truncate, saturation to WORD_SIZE and a pass-through tag.
module cmult_stream #(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = WORD_SIZE - 1,
    parameter int TAG_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [2*WORD_SIZE-1:0] A,
    input  logic [2*WORD_SIZE-1:0] B,
    input  logic                   i_conj,
    input  logic                   i_rnd,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [2*WORD_SIZE-1:0] C,
    output logic                   o_ovf,
    output logic [TAG_W-1:0]       o_tag
);
    localparam int W  = WORD_SIZE;
    localparam int PW = 2 * W;
    localparam int SW = PW + 1;
    localparam int RW = PW + 2;
    localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAXV = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Returns {clamped, value}: optional half-LSB add, arithmetic shift, clamp.
    function automatic logic [W:0] sat_round(input logic signed [SW-1:0] s, input logic rnd);
        logic signed [RW-1:0] r;
        r = RW'(s) + (rnd ? HALF : '0);
        r = r >>> FRAC_BITS;
        if (r > MAXV) return {1'b1, MAXV[W-1:0]};
        if (r < MINV) return {1'b1, MINV[W-1:0]};
        return {1'b0, r[W-1:0]};
    endfunction

    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic                 ld1, ld2, ld3;
    logic                 v1_q, v1_d, cj1_q, cj1_d, rn1_q, rn1_d;
    logic [TAG_W-1:0]     tag1_q, tag1_d;
    logic signed [PW-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
    logic                 v2_q, v2_d, rn2_q, rn2_d;
    logic [TAG_W-1:0]     tag2_q, tag2_d;
    logic signed [SW-1:0] re2_q, re2_d, im2_q, im2_d;
    logic [W:0]           sr, si;
    logic                 v3_q, v3_d, ovf3_q, ovf3_d;
    logic [W-1:0]         cre_q, cre_d, cim_q, cim_d;
    logic [TAG_W-1:0]     tag3_q, tag3_d;

    assign a_re = A[PW-1:W];
    assign a_im = A[W-1:0];
    assign b_re = B[PW-1:W];
    assign b_im = B[W-1:0];

    // Load chain runs back from the output so empty stages fill during a stall.
    assign ld3     = !v3_q || o_ready;
    assign ld2     = !v2_q || ld3;
    assign ld1     = !v1_q || ld2;
    assign i_ready = ld1;

    always_comb begin
        v1_d   = ld1 ? i_valid : v1_q;
        cj1_d  = ld1 ? i_conj : cj1_q;
        rn1_d  = ld1 ? i_rnd : rn1_q;
        tag1_d = ld1 ? i_tag : tag1_q;
        rr_d   = ld1 ? PW'(a_re) * PW'(b_re) : rr_q;
        ii_d   = ld1 ? PW'(a_im) * PW'(b_im) : ii_q;
        ri_d   = ld1 ? PW'(a_re) * PW'(b_im) : ri_q;
        ir_d   = ld1 ? PW'(a_im) * PW'(b_re) : ir_q;
        v2_d   = ld2 ? v1_q : v2_q;
        rn2_d  = ld2 ? rn1_q : rn2_q;
        tag2_d = ld2 ? tag1_q : tag2_q;
        re2_d  = ld2 ? (cj1_q ? SW'(rr_q) + SW'(ii_q) : SW'(rr_q) - SW'(ii_q)) : re2_q;
        im2_d  = ld2 ? (cj1_q ? SW'(ir_q) - SW'(ri_q) : SW'(ri_q) + SW'(ir_q)) : im2_q;
        sr     = sat_round(re2_q, rn2_q);
        si     = sat_round(im2_q, rn2_q);
        v3_d   = ld3 ? v2_q : v3_q;
        cre_d  = ld3 ? (v2_q ? sr[W-1:0] : '0) : cre_q;
        cim_d  = ld3 ? (v2_q ? si[W-1:0] : '0) : cim_q;
        ovf3_d = ld3 ? v2_q && (sr[W] || si[W]) : ovf3_q;
        tag3_d = ld3 ? (v2_q ? tag2_q : '0) : tag3_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            cj1_q  <= 1'b0;
            rn1_q  <= 1'b0;
            tag1_q <= '0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
            v2_q   <= 1'b0;
            rn2_q  <= 1'b0;
            tag2_q <= '0;
            re2_q  <= '0;
            im2_q  <= '0;
            v3_q   <= 1'b0;
            cre_q  <= '0;
            cim_q  <= '0;
            ovf3_q <= 1'b0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            cj1_q  <= cj1_d;
            rn1_q  <= rn1_d;
            tag1_q <= tag1_d;
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
            v2_q   <= v2_d;
            rn2_q  <= rn2_d;
            tag2_q <= tag2_d;
            re2_q  <= re2_d;
            im2_q  <= im2_d;
            v3_q   <= v3_d;
            cre_q  <= cre_d;
            cim_q  <= cim_d;
            ovf3_q <= ovf3_d;
            tag3_q <= tag3_d;
        end
    end

    assign o_valid = v3_q;
    assign C       = {cre_q, cim_q};
    assign o_ovf   = ovf3_q;
    assign o_tag   = tag3_q;
endmodule

// File: tb/tb_cmult_stream.sv
// tb_cmult_stream: directed and random checks of cmult_stream against an
// integer-arithmetic reference model with an in-order expectation queue.
module tb_cmult_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        i_conj = 1'b0;
    logic        i_rnd = 1'b0;
    logic [7:0]  i_tag = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [31:0] C;
    logic        o_ovf;
    logic [7:0]  o_tag;

    typedef struct {
        logic [31:0] c;
        logic        ovf;
        logic [7:0]  tag;
    } exp_t;

    exp_t        expq[$];
    exp_t        e_m;
    logic [7:0]  out_tags[$];
    int          checks = 0;
    int          errors = 0;
    logic        hold = 1'b0;
    logic [31:0] h_c;
    logic        h_ovf;
    logic [7:0]  h_tag;

    cmult_stream dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
        .A(A), .B(B), .i_conj(i_conj), .i_rnd(i_rnd), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready), .C(C), .o_ovf(o_ovf), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [16:0] qsat(input longint v, input logic rn);
        longint r;
        r = (v + (rn ? 64'sd16384 : 64'sd0)) >>> 15;
        if (r > 32767) return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    // Returns {ovf, C} for Q1.15 operands using plain integer complex math.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cj, input logic rn);
        longint ar, ai, br, bi, re, im;
        logic [16:0] sr, si;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        re = cj ? ar * br + ai * bi : ar * br - ai * bi;
        im = cj ? ai * br - ar * bi : ar * bi + ai * br;
        sr = qsat(re, rn);
        si = qsat(im, rn);
        return {sr[16] | si[16], sr[15:0], si[15:0]};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7fff;
            2: return 16'h4000;
            3: return 16'hc000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            expq.delete();
            hold = 1'b0;
            chk("rst_ovalid", 64'(o_valid), 64'd0);
            chk("rst_c", 64'(C), 64'd0);
        end else begin
            if (!o_valid) chk("idle_c", 64'(C), 64'd0);
            if (hold) begin
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_c", 64'(C), 64'(h_c));
                chk("stall_ovf", 64'(o_ovf), 64'(h_ovf));
                chk("stall_tag", 64'(o_tag), 64'(h_tag));
            end
            if (i_valid && i_ready) begin
                logic [32:0] m;
                m = model(A, B, i_conj, i_rnd);
                expq.push_back('{c: m[31:0], ovf: m[32], tag: i_tag});
            end
            if (o_valid && o_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got tag %0h C %0h want no output", o_tag, C);
                end else begin
                    e_m = expq.pop_front();
                    chk("out_c", 64'(C), 64'(e_m.c));
                    chk("out_ovf", 64'(o_ovf), 64'(e_m.ovf));
                    chk("out_tag", 64'(o_tag), 64'(e_m.tag));
                end
                out_tags.push_back(o_tag);
            end
            hold  = o_valid && !o_ready;
            h_c   = C;
            h_ovf = o_ovf;
            h_tag = o_tag;
        end
    end

    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic cj,
                            input logic rn, input logic [31:0] want, input logic want_ovf);
        int n;
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        i_valid = 1'b1;
        A = a;
        B = b;
        i_conj = cj;
        i_rnd = rn;
        i_tag = i_tag + 8'd1;
        @(negedge clk);
        chk("send_ready", 64'(i_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd2);
        chk("lit_c", 64'(C), 64'(want));
        chk("lit_ovf", 64'(o_ovf), 64'(want_ovf));
    endtask

    initial begin
        int acc, idx, guard;
        chk("model_mul", 64'(model(32'h4000_4000, 32'h4000_c000, 1'b0, 1'b0)), 64'h0_4000_0000);
        chk("model_sat", 64'(model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0)), 64'h1_7fff_0000);
        chk("model_cj1", 64'(model(32'h0000_4000, 32'h0000_4000, 1'b1, 1'b0)), 64'h0_2000_0000);
        chk("model_cj0", 64'(model(32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0)), 64'h0_e000_0000);
        chk("model_rnd", 64'(model(32'h0001_0000, 32'h4000_0000, 1'b0, 1'b1)), 64'h0_0001_0000);
        chk("model_trn", 64'(model(32'h0001_0000, 32'h4000_0000, 1'b0, 1'b0)), 64'h0_0000_0000);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(i_ready), 64'd1);

        send_one(32'h4000_4000, 32'h4000_c000, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
        send_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h7fff_0000, 1'b1);
        send_one(32'h0000_4000, 32'h0000_4000, 1'b1, 1'b0, 32'h2000_0000, 1'b0);
        send_one(32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0, 32'he000_0000, 1'b0);
        send_one(32'h0001_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h0001_0000, 1'b0);
        send_one(32'h0001_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // Stall: five back-to-back offers with the output blocked.
        repeat (3) @(posedge clk);
        out_tags.delete();
        acc = 0;
        idx = 1;
        #1;
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            i_valid = 1'b1;
            A = {8'(idx) << 4, 8'h00, 16'h2000};
            B = 32'h4000_e000;
            i_conj = idx[0];
            i_rnd = idx[1];
            i_tag = 8'(idx);
            @(negedge clk);
            if (i_ready) begin
                acc++;
                idx++;
            end
        end
        chk("stall_accepted", 64'(acc), 64'd3);
        chk("stall_iready", 64'(i_ready), 64'd0);
        chk("stall_head_tag", 64'(o_tag), 64'd1);
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        guard = 0;
        while (idx <= 5 && guard < 20) begin
            A = {8'(idx) << 4, 8'h00, 16'h2000};
            i_conj = idx[0];
            i_rnd = idx[1];
            i_tag = 8'(idx);
            @(negedge clk);
            if (i_ready) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        i_valid = 1'b0;
        repeat (6) @(posedge clk);
        chk("order_count", 64'(out_tags.size()), 64'd5);
        for (int k = 0; k < 5 && k < out_tags.size(); k++)
            chk("order_tag", 64'(out_tags[k]), 64'(k + 1));

        // Random stream with random backpressure and a mid-stream reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            i_valid = 1'($urandom_range(0, 1));
            o_ready = ($urandom_range(0, 3) != 0);
            A = {pick(), pick()};
            B = {pick(), pick()};
            i_conj = 1'($urandom_range(0, 1));
            i_rnd = 1'($urandom_range(0, 1));
            i_tag = 8'($urandom);
            if (cyc == 200) begin
                reset = 1'b0;
                #1;
                chk("async_clear_valid", 64'(o_valid), 64'd0);
                chk("async_clear_c", 64'(C), 64'd0);
            end
            if (cyc == 202) begin
                reset = 1'b1;
                @(negedge clk);
                chk("ready_after_pulse", 64'(i_ready), 64'd1);
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        guard = 0;
        while (expq.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
